fp_class_arb: RTL and testbench
===============================

Name: fp_class_arb

Overview:
- Round-robin arbiter and result register that shares one fp_class classifier/unpacker between N_REQ requesters.
- Each requester presents a packed IEEE-style operand with a valid/ready handshake.
- The block grants one requester per cycle and muxes its operand into the shared classifier.
- It registers the unpacked result (sign, exponent, mantissa, class flags, requester tag) toward a single downstream consumer. The downstream side can apply back-pressure.

Parameters:
- N_EXP, 11, exponent field width.
- N_MAN, 52, fraction field width.
- BIAS, (1 << (N_EXP-1)), exponent bias passed to fp_class.
- EMIN, (1-BIAS), minimum exponent passed to fp_class.
- N_REQ, 2, number of requesters (2..8).
- TAG_W, max(1, $clog2(N_REQ)), tag width.

Ports:
- clk  in  1  clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_data  in  N_REQ*(N_EXP+N_MAN+1)  packed operands; requester i occupies slice i.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_tag  out  TAG_W  index of the requester that produced the result.
- out_sign  out  1  operand sign bit.
- out_exp  out  N_EXP+2  signed unbiased exponent.
- out_man  out  N_MAN+1  mantissa, including the hidden bit.
- out_class  out  5  {nan, inf, zero, dnorm, norm}; exactly one bit set when out_valid=1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - out_valid=0.
  - out_tag, out_sign, out_exp, out_man, out_class all 0.
  - Round-robin pointer=0.
  - Any held result is discarded.
  - req_ready is combinationally 0 while rst=1.
- Register free: can_accept = !out_valid | out_ready.
- Grant:
  - When can_accept=1, grant the first requester with req_valid=1, searching circularly from ptr.
  - req_ready = one-hot(grant) & can_accept; req_ready is purely combinational.
- Transfer rules:
  - A request transfers on a cycle where req_valid[i] & req_ready[i].
  - An output transfers on a cycle where out_valid & out_ready.
- Latency: exactly 1 cycle. The granted operand is classified combinationally and captured at the same edge; out_valid=1 the next cycle.
- Throughput: 1 result per cycle when out_ready is held at 1. Output transfer and new capture in the same cycle is legal: the register is overwritten and out_valid stays 1.
- Pointer update: on each request transfer, ptr = (granted index + 1) mod N_REQ. Otherwise ptr holds.
- Idle: if there is no request transfer and an output transfer occurs, out_valid goes to 0.
- Stall: out_valid=1 & out_ready=0 gives req_ready=0. All result outputs hold stable; no overwrite.
- Requester obligation: hold req_data stable while req_valid & !req_ready. The block does not check this.
- Unpack rules (fp_class semantics):
  - norm: out_exp = field − BIAS; out_man = {1, frac}.
  - dnorm: out_exp = EMIN − lz, where lz is the leading-zero count of the N_MAN-bit frac; out_man = {0, frac}, unshifted.
  - zero, inf, nan: out_exp = raw field zero-extended; out_man = {0, frac}.
  - out_sign = operand MSB in all classes.
- Single active requester: it is granted every accept cycle (no bubbles).
- Reset mid-stall: the held result is dropped, never delivered, and out_valid=0 the cycle after reset.

Decomposition:
- Shared package fp_pkg:
  - class bit indices CLS_NAN=4, CLS_INF=3, CLS_ZERO=2, CLS_DNORM=1, CLS_NORM=0;
  - operand width localparam N_EXP+N_MAN+1;
  - BIAS/EMIN defaults.
- Sub-module: one instance of the existing fp_class on the muxed operand, with parameters N_EXP, N_MAN, BIAS, EMIN passed through.
- The round-robin grant logic stays inline.

Test Plan:
- Reset/idle: assert rst for 2 cycles with req_valid=2'b11 → out_valid=0, req_ready=0 during reset; first grant after release goes to requester 0.
- Norm unpack: req0 sends 0x3FF0000000000000 with out_ready=1 → next cycle out_valid=1, tag=0, sign=0, exp=−1 (BIAS=1024), man=0x10000000000000, class=5'b00001.
- Denormal: req1 sends 0x0000000000000001 → exp=−1074, man=0x00000000000001, class=5'b00010. Also 0x8000000000000000 → sign=1, class=5'b00100.
- Fairness: both requesters valid continuously, out_ready=1 → out_tag sequence 0,1,0,1,… and one result per cycle with no bubbles.
- Back-pressure: out_ready=0 for 5 cycles while both requesters are valid → req_ready=0 and outputs frozen for those cycles. Then out_ready=1 → a new capture occurs in the same cycle as the drain, and tags continue round-robin.
- Special values and mid-stall reset: 0x7FF0000000000000 → class inf; 0x7FF8000000000000 → class nan. Then assert rst while stalled → out_valid=0 next cycle and the held result is never delivered.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants and helpers for the floating-point
//                classifier and its round-robin front end.
//  Revision    : 1.0
// ============================================================================
package fp_pkg;

  // Bit positions inside the 5-bit class vector {nan, inf, zero, dnorm, norm}
  localparam int CLS_NAN   = 4;
  localparam int CLS_INF   = 3;
  localparam int CLS_ZERO  = 2;
  localparam int CLS_DNORM = 1;
  localparam int CLS_NORM  = 0;

  // Default field widths (binary64 layout)
  localparam int FP_N_EXP  = 11;
  localparam int FP_N_MAN  = 52;

  // Packed operand width: sign + exponent field + fraction field
  function automatic int op_width(input int n_exp, input int n_man);
    return n_exp + n_man + 1;
  endfunction

  // Default exponent bias for a given exponent field width
  function automatic int fp_bias(input int n_exp);
    return 1 << (n_exp - 1);
  endfunction

  // Default minimum (denormal) exponent for a given bias
  function automatic int fp_emin(input int bias);
    return 1 - bias;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_class.sv
`default_nettype none
// ============================================================================
//  Module      : fp_class
//  Description : Combinational classifier/unpacker for a packed IEEE-style
//                operand. Produces sign, signed unbiased exponent, mantissa
//                with hidden bit and a one-hot class vector.
//  Revision    : 1.0
// ============================================================================
module fp_class
  import fp_pkg::*;
#(
  parameter int N_EXP = FP_N_EXP,
  parameter int N_MAN = FP_N_MAN,
  parameter int BIAS  = fp_bias(N_EXP),
  parameter int EMIN  = fp_emin(BIAS)
) (
  input  logic [op_width(N_EXP, N_MAN)-1:0] i_op,
  output logic                              o_sign,
  output logic [N_EXP+1:0]                  o_exp,
  output logic [N_MAN:0]                    o_man,
  output logic [4:0]                        o_class
);

  localparam int c_OP_W = op_width(N_EXP, N_MAN);
  localparam int c_LZ_W = $clog2(N_MAN + 1);
  localparam int c_E_W  = N_EXP + 2;

  // Exponent arithmetic is done modulo 2^c_E_W; the result reads as signed.
  localparam logic [c_E_W-1:0] c_BIAS_E = c_E_W'(BIAS);
  localparam logic [c_E_W-1:0] c_EMIN_E = c_E_W'(EMIN);

  logic [N_EXP-1:0]  w_field;
  logic [N_MAN-1:0]  w_frac;
  logic              w_exp_max;
  logic              w_exp_zero;
  logic              w_frac_zero;
  logic [c_LZ_W-1:0] w_lz;
  logic              w_lz_found;

  assign o_sign      = i_op[c_OP_W-1];
  assign w_field     = i_op[c_OP_W-2 -: N_EXP];
  assign w_frac      = i_op[N_MAN-1:0];
  assign w_exp_max   = &w_field;
  assign w_exp_zero  = ~|w_field;
  assign w_frac_zero = ~|w_frac;

  // Leading-zero count of the fraction, scanning from the MSB down
  always_comb begin
    w_lz       = '0;
    w_lz_found = 1'b0;
    for (int i = N_MAN - 1; i >= 0; i--) begin
      if (!w_lz_found) begin
        if (w_frac[i]) begin
          w_lz_found = 1'b1;
        end else begin
          w_lz = w_lz + c_LZ_W'(1);
        end
      end
    end
  end

  // Classify and unpack; specials keep the raw field and unshifted fraction
  always_comb begin
    o_class = '0;
    o_exp   = {2'b00, w_field};
    o_man   = {1'b0, w_frac};
    if (w_exp_max) begin
      if (w_frac_zero) begin
        o_class[CLS_INF] = 1'b1;
      end else begin
        o_class[CLS_NAN] = 1'b1;
      end
    end else if (w_exp_zero) begin
      if (w_frac_zero) begin
        o_class[CLS_ZERO] = 1'b1;
      end else begin
        o_class[CLS_DNORM] = 1'b1;
        o_exp = c_EMIN_E - {{(c_E_W - c_LZ_W){1'b0}}, w_lz};
      end
    end else begin
      o_class[CLS_NORM] = 1'b1;
      o_exp = {2'b00, w_field} - c_BIAS_E;
      o_man = {1'b1, w_frac};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_class_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fp_class_arb
//  Description : Round-robin arbiter sharing one fp_class unpacker between
//                N_REQ requesters, with a single registered result stage
//                toward a back-pressurable consumer.
//  Revision    : 1.0
// ============================================================================
module fp_class_arb
  import fp_pkg::*;
#(
  parameter int N_EXP = FP_N_EXP,
  parameter int N_MAN = FP_N_MAN,
  parameter int BIAS  = fp_bias(N_EXP),
  parameter int EMIN  = fp_emin(BIAS),
  parameter int N_REQ = 2,
  parameter int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_REQ-1:0]                        req_valid,
  output logic [N_REQ-1:0]                        req_ready,
  input  logic [N_REQ*op_width(N_EXP, N_MAN)-1:0] req_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [TAG_W-1:0]                        out_tag,
  output logic                                    out_sign,
  output logic [N_EXP+1:0]                        out_exp,
  output logic [N_MAN:0]                          out_man,
  output logic [4:0]                              out_class
);

  localparam int c_OP_W = op_width(N_EXP, N_MAN);

  logic [TAG_W-1:0]  r_ptr;
  logic              r_out_valid;
  logic [TAG_W-1:0]  r_tag;
  logic              r_sign;
  logic [N_EXP+1:0]  r_exp;
  logic [N_MAN:0]    r_man;
  logic [4:0]        r_class;

  logic              w_can_accept;
  logic              w_gnt_any;
  logic [TAG_W-1:0]  w_gnt_idx;
  logic [TAG_W-1:0]  w_ptr_nxt;
  logic              w_xfer;
  logic [N_REQ-1:0]  w_ready;
  logic [c_OP_W-1:0] w_op;
  logic              w_sign;
  logic [N_EXP+1:0]  w_exp;
  logic [N_MAN:0]    w_man;
  logic [4:0]        w_class;

  // The result slot is free when empty or being drained this cycle
  assign w_can_accept = !r_out_valid || out_ready;

  // Circular first-valid search from r_ptr: indices >= ptr first, then wrap
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_gnt_any && req_valid[i] && (TAG_W'(i) >= r_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = TAG_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_gnt_any && req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = TAG_W'(i);
      end
    end
  end

  assign w_xfer    = w_gnt_any && w_can_accept && !rst;
  assign w_ptr_nxt = (w_gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : (w_gnt_idx + TAG_W'(1));

  // One-hot accept toward the granted requester only
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready[i] = w_xfer && (w_gnt_idx == TAG_W'(i));
    end
  end

  assign req_ready = w_ready;

  // Route the granted requester's operand into the shared classifier
  always_comb begin
    w_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == TAG_W'(i)) begin
        w_op = req_data[i*c_OP_W +: c_OP_W];
      end
    end
  end

  fp_class #(
    .N_EXP (N_EXP),
    .N_MAN (N_MAN),
    .BIAS  (BIAS),
    .EMIN  (EMIN)
  ) u_fp_class (
    .i_op    (w_op),
    .o_sign  (w_sign),
    .o_exp   (w_exp),
    .o_man   (w_man),
    .o_class (w_class)
  );

  // Result register: capture on request transfer, clear on drain-without-refill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_tag       <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_man       <= '0;
      r_class     <= '0;
    end else if (w_xfer) begin
      r_ptr       <= w_ptr_nxt;
      r_out_valid <= 1'b1;
      r_tag       <= w_gnt_idx;
      r_sign      <= w_sign;
      r_exp       <= w_exp;
      r_man       <= w_man;
      r_class     <= w_class;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_tag   = r_tag;
  assign out_sign  = r_sign;
  assign out_exp   = r_exp;
  assign out_man   = r_man;
  assign out_class = r_class;

endmodule
`default_nettype wire

// File: tb/tb_fp_class_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_class_arb
//  Description : Directed self-checking bench for fp_class_arb (N_REQ=2,
//                binary64 layout, BIAS=1024).
//  Revision    : 1.0
// ============================================================================
module tb_fp_class_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:0]   out_tag;
  logic         out_sign;
  logic [12:0]  out_exp;
  logic [52:0]  out_man;
  logic [4:0]   out_class;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          who;
    logic [63:0] op;
    logic        sg;
    logic [12:0] ex;
    logic [52:0] mn;
    logic [4:0]  cl;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  fp_class_arb #(
    .N_EXP (11),
    .N_MAN (52),
    .N_REQ (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_class (out_class)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{0, 64'h3FF0000000000000, 1'b0, 13'h1FFF, 53'h10000000000000, 5'b00001};
    tbl[1] = '{1, 64'h0000000000000001, 1'b0, 13'h1BCE, 53'h00000000000001, 5'b00010};
    tbl[2] = '{0, 64'h8000000000000000, 1'b1, 13'h0000, 53'h00000000000000, 5'b00100};
    tbl[3] = '{1, 64'h7FF0000000000000, 1'b0, 13'h07FF, 53'h00000000000000, 5'b01000};
    tbl[4] = '{0, 64'h7FF8000000000000, 1'b0, 13'h07FF, 53'h08000000000000, 5'b10000};
    tbl[5] = '{1, 64'hC000000000000000, 1'b1, 13'h0000, 53'h10000000000000, 5'b00001};
    tbl[6] = '{0, 64'h0008000000000000, 1'b0, 13'h1C01, 53'h08000000000000, 5'b00010};
    tbl[7] = '{1, 64'h0010000000000000, 1'b0, 13'h1C01, 53'h10000000000000, 5'b00001};

    // Reset with both requesters asking: nothing accepted, nothing valid
    rst       = 1'b1;
    req_valid = 2'b11;
    req_data  = {64'h4008000000000000, 64'h3FF0000000000000};
    out_ready = 1'b1;
    #1;
    chk("rst_ready_comb", 64'(req_ready), 64'h0);
    repeat (2) begin
      tick();
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_class", 64'(out_class), 64'h0);
    end
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);

    // Fairness: alternating tags, one result per cycle
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fair_valid", 64'(out_valid), 64'h1);
      chk("fair_tag", 64'(out_tag), 64'(i % 2));
      chk("fair_man", 64'(out_man), (i % 2 == 0) ? 64'h10000000000000 : 64'h18000000000000);
    end

    // Back-pressure: tag 1 result held for 5 cycles, no accepts
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'h0);
      tick();
      chk("bp_valid", 64'(out_valid), 64'h1);
      chk("bp_tag", 64'(out_tag), 64'h1);
      chk("bp_man", 64'(out_man), 64'h18000000000000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h1);
    tick();
    chk("bp_drain_valid", 64'(out_valid), 64'h1);
    chk("bp_drain_tag", 64'(out_tag), 64'h0);
    chk("bp_drain_man", 64'(out_man), 64'h10000000000000);
    tick();
    chk("bp_next_tag", 64'(out_tag), 64'h1);

    // Idle: drained with no new request
    req_valid = 2'b00;
    tick();
    chk("idle_valid", 64'(out_valid), 64'h0);

    // Table of single-requester unpack vectors
    for (int v = 0; v < 8; v++) begin
      req_valid = (tbl[v].who == 0) ? 2'b01 : 2'b10;
      req_data  = (tbl[v].who == 0) ? {64'h0, tbl[v].op} : {tbl[v].op, 64'h0};
      #1;
      chk("vec_ready", 64'(req_ready), (tbl[v].who == 0) ? 64'h1 : 64'h2);
      tick();
      req_valid = 2'b00;
      chk("vec_valid", 64'(out_valid), 64'h1);
      chk("vec_tag", 64'(out_tag), 64'(tbl[v].who));
      chk("vec_sign", 64'(out_sign), 64'(tbl[v].sg));
      chk("vec_exp", 64'(out_exp), 64'(tbl[v].ex));
      chk("vec_man", 64'(out_man), 64'(tbl[v].mn));
      chk("vec_class", 64'(out_class), 64'(tbl[v].cl));
    end

    // Mid-stall reset: a held NaN result must never be delivered
    tick();
    chk("ms_drained", 64'(out_valid), 64'h0);
    req_valid = 2'b10;
    req_data  = {64'h7FF8000000000000, 64'h0};
    out_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    chk("ms_cap_valid", 64'(out_valid), 64'h1);
    chk("ms_cap_class", 64'(out_class), 64'h10);
    chk("ms_cap_tag", 64'(out_tag), 64'h1);
    repeat (2) tick();
    chk("ms_hold_valid", 64'(out_valid), 64'h1);
    chk("ms_hold_exp", 64'(out_exp), 64'h7FF);
    rst = 1'b1;
    tick();
    chk("ms_rst_valid", 64'(out_valid), 64'h0);
    chk("ms_rst_class", 64'(out_class), 64'h0);
    chk("ms_rst_exp", 64'(out_exp), 64'h0);
    chk("ms_rst_man", 64'(out_man), 64'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_never_delivered", 64'(out_valid), 64'h0);
    end
    req_valid = 2'b11;
    #1;
    chk("ms_ptr_reset", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("ms_after_tag", 64'(out_tag), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
